// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: source encoding and the request record.
`ifndef NUM_REGS
`define NUM_REGS 16
`endif
`ifndef NUM_REGS_BIT_COUNT
`define NUM_REGS_BIT_COUNT 4
`endif
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

package wb_pkg;

    localparam int WB_ADDR_W = `NUM_REGS_BIT_COUNT;
    localparam int WB_DATA_W = `INSTRUCTION_WIDTH;

    typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} wb_src_t;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Grant is combinational; the priority pointer
// moves to the losing side whenever a grant is consumed.
//
// rr_ptr  | meaning
// SRC_ALU | ALU wins when both request
// SRC_MEM | MEM wins when both request
module rr_arbiter2
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,      // bit 0 = ALU, bit 1 = MEM
    input  logic       advance,
    output logic [1:0] gnt
);

    wb_src_t rr_ptr;

    // Single requester wins outright; on contention the pointer decides.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (rr_ptr == SRC_ALU) ? 2'b01 : 2'b10;
        end
    end

    // Point at whichever side did not get this grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= SRC_ALU;
        end else if (advance) begin
            rr_ptr <= gnt[0] ? SRC_MEM : SRC_ALU;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write client: arbitrates ALU and load results, drives a
// registered write port, tracks per-register busy bits and flags stray writebacks.
`ifndef NUM_REGS
`define NUM_REGS 16
`endif
`ifndef NUM_REGS_BIT_COUNT
`define NUM_REGS_BIT_COUNT 4
`endif
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_REGS = `NUM_REGS,
    parameter int ADDR_W   = `NUM_REGS_BIT_COUNT,
    parameter int DATA_W   = `INSTRUCTION_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd_addr,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_rd_addr,
    input  logic [DATA_W-1:0]   alu_rd_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDR_W-1:0]   mem_rd_addr,
    input  logic [DATA_W-1:0]   mem_rd_data,
    output logic                rd_write_en,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic [NUM_REGS-1:0] busy,
    output logic                wb_err
);

    logic [1:0]          gnt;
    logic                accept;
    wb_req_t             sel_req;
    logic [NUM_REGS-1:0] busy_next;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({mem_valid, alu_valid}),
        .advance (accept),
        .gnt     (gnt)
    );

    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];
    assign accept    = |gnt;

    // Mux the granted source into a single request record.
    always_comb begin
        sel_req.addr = alu_rd_addr;
        sel_req.data = alu_rd_data;
        if (gnt[1]) begin
            sel_req.addr = mem_rd_addr;
            sel_req.data = mem_rd_data;
        end
    end

    // Clear on commit first, then set on issue so a re-issue of the same register wins.
    always_comb begin
        busy_next = busy;
        if (rd_write_en) begin
            busy_next[rd_addr] = 1'b0;
        end
        if (issue_valid) begin
            busy_next[issue_rd_addr] = 1'b1;
        end
    end

    // Registered write port: one write per accepted transfer, address/data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_write_en <= 1'b0;
            rd_addr     <= '0;
            rd_data     <= '0;
        end else begin
            rd_write_en <= accept;
            if (accept) begin
                rd_addr <= sel_req.addr;
                rd_data <= sel_req.data;
            end
        end
    end

    // Busy scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Sticky error: a result arrived for a register nobody was waiting on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_err <= 1'b0;
        end else if (accept && !busy[sel_req.addr]) begin
            wb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: table-driven handshake vectors with
// a queue of expected register-file writes, plus hand-written corner sequences.
`ifndef NUM_REGS
`define NUM_REGS 16
`endif
`ifndef NUM_REGS_BIT_COUNT
`define NUM_REGS_BIT_COUNT 4
`endif
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module tb_writeback_arbiter;

    localparam int NR = `NUM_REGS;
    localparam int AW = `NUM_REGS_BIT_COUNT;
    localparam int DW = `INSTRUCTION_WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid;
    logic [AW-1:0] issue_rd_addr;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd_addr;
    logic [DW-1:0] alu_rd_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          rd_write_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [NR-1:0] busy;
    logic          wb_err;

    always #5 clk = ~clk;

    writeback_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rd_addr (issue_rd_addr),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd_addr   (alu_rd_addr),
        .alu_rd_data   (alu_rd_data),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .rd_write_en   (rd_write_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .busy          (busy),
        .wb_err        (wb_err)
    );

    typedef struct {
        logic          iv;
        logic [AW-1:0] ia;
        logic          av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          mv;
        logic [AW-1:0] ma;
        logic [DW-1:0] md;
        logic [1:0]    g;    // expected grant {mem, alu}
    } vec_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    vec_t tbl[$];
    wr_t  exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    function automatic vec_t mk(int iv, int ia, int av, int aa, logic [DW-1:0] ad,
                                int mv, int ma, logic [DW-1:0] md, int g);
        vec_t v;
        v.iv = (iv != 0);
        v.ia = AW'(ia);
        v.av = (av != 0);
        v.aa = AW'(aa);
        v.ad = ad;
        v.mv = (mv != 0);
        v.ma = AW'(ma);
        v.md = md;
        v.g  = 2'(g);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        alu_valid   = 1'b0;
        mem_valid   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle per vector: drive, check the grant mid-cycle, record the expected write.
    task automatic apply(input vec_t v, input string name);
        issue_valid   = v.iv;
        issue_rd_addr = v.ia;
        alu_valid     = v.av;
        alu_rd_addr   = v.aa;
        alu_rd_data   = v.ad;
        mem_valid     = v.mv;
        mem_rd_addr   = v.ma;
        mem_rd_data   = v.md;
        @(negedge clk);
        chk({name, "_alu_ready"}, 64'(alu_ready), 64'(v.g[0]));
        chk({name, "_mem_ready"}, 64'(mem_ready), 64'(v.g[1]));
        if (v.g[0]) exp_q.push_back('{v.aa, v.ad});
        else if (v.g[1]) exp_q.push_back('{v.ma, v.md});
        tick();
        idle();
    endtask

    task automatic run_tbl(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("%s%0d", tag, i));
        end
        tbl.delete();
    endtask

    // Every accepted transfer must show up as exactly one write on the next cycle.
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            if (rd_write_en) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_write: got write to r%0d, required no write", rd_addr);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("wr_addr", 64'(rd_addr), 64'(w.a));
                    chk("wr_data", 64'(rd_data), 64'(w.d));
                end
            end else if (exp_q.size() != 0) begin
                compared++;
                mismatched++;
                $display("FAIL missing_write: got rd_write_en=0, required write to r%0d", exp_q[0].a);
                exp_q.delete();
            end
        end
    end

    initial begin
        rst           = 1'b1;
        issue_rd_addr = '0;
        alu_rd_addr   = '0;
        alu_rd_data   = '0;
        mem_rd_addr   = '0;
        mem_rd_data   = '0;
        idle();
        #1;
        repeat (2) tick();
        chk("rst_we",   64'(rd_write_en), 64'd0);
        chk("rst_addr", 64'(rd_addr),     64'd0);
        chk("rst_data", 64'(rd_data),     64'd0);
        chk("rst_busy", 64'(busy),        64'd0);
        chk("rst_err",  64'(wb_err),      64'd0);
        rst = 1'b0;
        tick();

        // ALU-only writeback of an issued register
        tbl.push_back(mk(1, 5, 0, 0, '0, 0, 0, '0, 0));
        run_tbl("iss5_");
        chk("busy5_set", 64'(busy[5]), 64'd1);
        tbl.push_back(mk(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, '0, 1));
        run_tbl("alu5_");
        chk("alu5_we",    64'(rd_write_en), 64'd1);
        chk("alu5_addr",  64'(rd_addr),     64'd5);
        chk("alu5_data",  64'(rd_data),     64'hDEADBEEF);
        chk("busy5_hold", 64'(busy[5]),     64'd1);
        tick();
        chk("busy5_clr",  64'(busy[5]),     64'd0);
        chk("alu5_idle",  64'(rd_write_en), 64'd0);
        chk("alu5_err",   64'(wb_err),      64'd0);

        // Stray MEM writeback to r12: write happens, error latches
        tbl.push_back(mk(0, 0, 0, 0, '0, 1, 12, 32'h12345678, 2));
        run_tbl("err12_");
        chk("err12_we",   64'(rd_write_en), 64'd1);
        chk("err12_addr", 64'(rd_addr),     64'd12);
        chk("err12_flag", 64'(wb_err),      64'd1);
        tick();

        // Issue r1-r4 and r8-r11, then continuous contention
        for (int i = 1; i <= 4; i++) tbl.push_back(mk(1, i, 0, 0, '0, 0, 0, '0, 0));
        for (int i = 8; i <= 11; i++) tbl.push_back(mk(1, i, 0, 0, '0, 0, 0, '0, 0));
        run_tbl("iss_");
        chk("busy_issued", 64'(busy), 64'h0F1E);
        tbl.push_back(mk(0, 0, 1, 1, 32'hA1, 1, 8, 32'hB8, 1));
        tbl.push_back(mk(0, 0, 1, 2, 32'hA2, 1, 8, 32'hB8, 2));
        tbl.push_back(mk(0, 0, 1, 2, 32'hA2, 1, 9, 32'hB9, 1));
        tbl.push_back(mk(0, 0, 1, 3, 32'hA3, 1, 9, 32'hB9, 2));
        run_tbl("cont_");
        tick();
        chk("busy_after_cont", 64'(busy),   64'h0C18);
        chk("err_sticky1",     64'(wb_err), 64'd1);

        // Same register cleared by commit and re-issued in one cycle
        tbl.push_back(mk(0, 0, 1, 3, 32'hC3, 0, 0, '0, 1));
        tbl.push_back(mk(1, 3, 0, 0, '0, 0, 0, '0, 0));
        run_tbl("same_");
        chk("same_busy3", 64'(busy[3]), 64'd1);
        chk("same_busy",  64'(busy),    64'h0C18);

        // Different registers cleared and set in one cycle
        tbl.push_back(mk(0, 0, 1, 3, 32'hD3, 0, 0, '0, 1));
        tbl.push_back(mk(1, 7, 0, 0, '0, 0, 0, '0, 0));
        run_tbl("diff_");
        chk("diff_busy3",  64'(busy[3]), 64'd0);
        chk("diff_busy7",  64'(busy[7]), 64'd1);
        chk("diff_busy",   64'(busy),    64'h0C90);
        chk("err_sticky2", 64'(wb_err),  64'd1);

        // Clean slate, then reset in the middle of a write cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 4; i <= 7; i++) tbl.push_back(mk(1, i, 0, 0, '0, 0, 0, '0, 0));
        tbl.push_back(mk(0, 0, 1, 4, 32'hE4, 0, 0, '0, 1));
        run_tbl("pre_rst_");
        chk("pre_rst_we",   64'(rd_write_en), 64'd1);
        chk("pre_rst_busy", 64'(busy),        64'h00F0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_we",   64'(rd_write_en), 64'd0);
        chk("mid_rst_addr", 64'(rd_addr),     64'd0);
        chk("mid_rst_data", 64'(rd_data),     64'd0);
        chk("mid_rst_busy", 64'(busy),        64'd0);
        chk("mid_rst_err",  64'(wb_err),      64'd0);
        tick();
        chk("rst_no_write", 64'(rd_write_en), 64'd0);
        rst = 1'b0;
        tick();
        tbl.push_back(mk(0, 0, 1, 1, 32'hF1, 1, 2, 32'hF2, 1));
        tbl.push_back(mk(0, 0, 1, 6, 32'hF6, 1, 2, 32'hF2, 2));
        run_tbl("post_rst_");
        tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
